// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between fetch and data stages; data has priority.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after MAX_DATA_BURST contested data grants.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    flush_i,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_stall_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_stall_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_WIDTH/8;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic                  is_data;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
  } txn_t;

  state_e                state_q, state_d;
  txn_t                  txn_q, txn_d;
  logic                  discard_q;
  logic                  if_rvalid_q, d_rvalid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, d_rdata_q;
  logic                  arb_fire, capture, grant_data;

  assign arb_fire = (state_q == IDLE) & (if_req_i | d_req_i);
  assign capture  = (state_q == RESP) & mem_rvalid_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_DATA_BURST+1);
  logic [CNT_W-1:0] burst_q;
  logic             force_fetch;

  assign force_fetch = (burst_q == CNT_W'(MAX_DATA_BURST)) & if_req_i & d_req_i;
  assign grant_data  = d_req_i & ~force_fetch;

  // Counts consecutive data grants that left a fetch waiting; never exceeds MAX_DATA_BURST.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       burst_q <= '0;
    else if (arb_fire) burst_q <= (grant_data & if_req_i) ? burst_q + 1'b1 : '0;
  end
`else
  assign grant_data = d_req_i;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req_i | d_req_i) state_d = REQ;
      REQ:     if (mem_gnt_i)          state_d = RESP;
      RESP:    if (mem_rvalid_i)       state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Output logic: memory fields always come from the latched transaction
  always_comb begin
    mem_req_o   = (state_q == REQ);
    mem_we_o    = txn_q.we;
    mem_addr_o  = txn_q.addr;
    mem_wdata_o = txn_q.wdata;
    mem_be_o    = txn_q.be;
  end

  always_comb begin
    txn_d = txn_q;
    if (arb_fire) begin
      txn_d.is_data = grant_data;
      txn_d.we      = grant_data & d_we_i;
      txn_d.addr    = grant_data ? d_addr_i  : if_addr_i;
      txn_d.wdata   = grant_data ? d_wdata_i : '0;
      txn_d.be      = grant_data ? d_be_i    : '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txn_q       <= '0;
      discard_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      txn_q       <= txn_d;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (state_q == IDLE)                discard_q <= 1'b0;
      else if (flush_i & ~txn_q.is_data)  discard_q <= 1'b1;
      if (capture) begin
        if (txn_q.is_data) begin
          d_rvalid_q <= 1'b1;
          if (!txn_q.we) d_rdata_q <= mem_rdata_i;
        end else if (!(discard_q | flush_i)) begin
          // A flush in the capture cycle itself must also drop the response.
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= mem_rdata_i;
        end
      end
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_stall_o  = if_req_i & ~if_rvalid_q;
  assign d_stall_o   = d_req_i & ~d_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int MDB = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i, flush_i, if_rvalid_o, if_stall_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_rvalid_o, d_stall_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [3:0]  d_be_i, mem_be_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  int checks = 0, errors = 0;

  wire [137:0] all_outs = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, if_rvalid_o,
                           if_rdata_o, d_rvalid_o, d_rdata_o, if_stall_o, d_stall_o};

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_BURST(MDB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_i(flush_i),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i));

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic clear_inputs();
    if_req_i = 0; if_addr_i = 0; flush_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0;
    d_wdata_i = 0; d_be_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0; clear_inputs();
    tick(); tick();
    rst_ni = 1;
  endtask

  task automatic test_reset();
    rst_ni = 0; clear_inputs();
    tick(); tick();
    checks++; if (all_outs !== '0) begin errors++; $display("FAIL reset_outs: got %h exp 0", all_outs); end
    rst_ni = 1;
    tick();
    checks++; if (all_outs !== '0) begin errors++; $display("FAIL post_reset_idle: got %h exp 0", all_outs); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req_i = 1; if_addr_i = 32'h100; #1;
    checks++; if ({if_stall_o, mem_req_o} !== 2'b10) begin errors++; $display("FAIL sf_c0 stall/req: got %b exp 10", {if_stall_o, mem_req_o}); end
    tick();
    checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      errors++; $display("FAIL sf_c1 mem: got %b %b %h %h exp 1 0 100 f", mem_req_o, mem_we_o, mem_addr_o, mem_be_o); end
    checks++; if (if_stall_o !== 1'b1) begin errors++; $display("FAIL sf_c1 stall: got %b exp 1", if_stall_o); end
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    checks++; if ({mem_req_o, if_stall_o, if_rvalid_o} !== 3'b010) begin
      errors++; $display("FAIL sf_c2 req/stall/rv: got %b exp 010", {mem_req_o, if_stall_o, if_rvalid_o}); end
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 32'hFFFF_FFFF;
    checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h13}) begin
      errors++; $display("FAIL sf_c3 resp: got %b %h exp 1 00000013", if_rvalid_o, if_rdata_o); end
    if_req_i = 0; #1;
    checks++; if (if_stall_o !== 1'b0) begin errors++; $display("FAIL sf_c3 stall: got %b exp 0", if_stall_o); end
    tick();
    checks++; if ({if_rvalid_o, if_rdata_o, mem_req_o} !== {1'b0, 32'h13, 1'b0}) begin
      errors++; $display("FAIL sf_c4 hold: got %b %h %b exp 0 00000013 0", if_rvalid_o, if_rdata_o, mem_req_o); end
  endtask

  task automatic test_priority();
    do_reset();
    if_req_i = 1; if_addr_i = 32'h104;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'hF;
    tick();
    checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== {2'b11, 32'h200, 32'hDEAD_BEEF, 4'hF}) begin
      errors++; $display("FAIL prio_data_first: got %b%b %h %h %h", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o); end
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55AA_55AA;
    tick();
    mem_rvalid_i = 0;
    checks++; if ({d_rvalid_o, if_rvalid_o, d_rdata_o} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL prio_store_resp: got %b %b %h exp 1 0 00000000", d_rvalid_o, if_rvalid_o, d_rdata_o); end
    d_req_i = 0;
    tick();
    checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o} !== {2'b10, 32'h104, 4'hF}) begin
      errors++; $display("FAIL prio_fetch_next: got %b%b %h %h", mem_req_o, mem_we_o, mem_addr_o, mem_be_o); end
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0010_0093;
    tick();
    mem_rvalid_i = 0;
    checks++; if ({if_rvalid_o, if_rdata_o, d_rdata_o} !== {1'b1, 32'h0010_0093, 32'h0}) begin
      errors++; $display("FAIL prio_fetch_resp: got %b %h %h", if_rvalid_o, if_rdata_o, d_rdata_o); end
    if_req_i = 0;
  endtask

  task automatic test_gnt_delay();
    do_reset();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h40; d_wdata_i = 32'h1234_5678; d_be_i = 4'h3;
    for (int c = 1; c <= 4; c++) begin
      tick();
      flush_i = (c == 2);
      checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== {2'b10, 32'h40, 32'h1234_5678, 4'h3}) begin
        errors++; $display("FAIL gd_stable c%0d: got %b%b %h %h %h", c, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o); end
      mem_gnt_i = (c == 4);
    end
    tick();
    flush_i = 0; mem_gnt_i = 0;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL gd_req_drop: got %b exp 0", mem_req_o); end
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    tick();
    mem_rvalid_i = 0;
    checks++; if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL gd_load_resp: got %b %h exp 1 cafef00d", d_rvalid_o, d_rdata_o); end
    d_req_i = 0;
  endtask

  task automatic test_flush();
    do_reset();
    if_req_i = 1; if_addr_i = 32'h180;
    tick(); mem_gnt_i = 1;
    tick(); mem_gnt_i = 0; flush_i = 1;
    tick(); flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0BAD_0BAD; if_addr_i = 32'h300;
    tick(); mem_rvalid_i = 0;
    checks++; if ({if_rvalid_o, if_rdata_o, mem_req_o} !== {1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL flush_resp_drop: got %b %h %b exp 0 00000000 0", if_rvalid_o, if_rdata_o, mem_req_o); end
    tick();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h300}) begin
      errors++; $display("FAIL flush_refetch: got %b %h exp 1 00000300", mem_req_o, mem_addr_o); end
    mem_gnt_i = 1;
    tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h73;
    tick(); mem_rvalid_i = 0;
    checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h73}) begin
      errors++; $display("FAIL flush_refetch_resp: got %b %h exp 1 00000073", if_rvalid_o, if_rdata_o); end
    if_req_i = 0;
    tick(); if_req_i = 1; if_addr_i = 32'h304;
    tick(); mem_gnt_i = 1;
    tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF; flush_i = 1;
    tick(); mem_rvalid_i = 0; flush_i = 0;
    checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b0, 32'h73}) begin
      errors++; $display("FAIL flush_capture_cycle: got %b %h exp 0 00000073", if_rvalid_o, if_rdata_o); end
    if_req_i = 0;
  endtask

  task automatic test_starve();
    byte order [5];
    int  n = 0;
    bit  prev = 0, rv_next = 0;
    do_reset();
    if_req_i = 1; if_addr_i = 32'h108;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h10; d_be_i = 4'hF;
    for (int cyc = 0; cyc < 200 && n < 5; cyc++) begin
      tick();
      mem_gnt_i = 0; mem_rvalid_i = 0;
      if (mem_req_o && !prev) begin order[n] = (mem_addr_o == 32'h10) ? "D" : "F"; n++; end
      if (rv_next) begin mem_rvalid_i = 1; rv_next = 0; end
      else if (mem_req_o) begin mem_gnt_i = 1; rv_next = 1; end
      prev = mem_req_o;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL starve_timeout: got %0d grants exp 5", n); end
    for (int i = 0; i < n; i++) begin
      byte exp_o;
      exp_o = (GUARD && i == MDB) ? "F" : "D";
      checks++; if (order[i] != exp_o) begin errors++; $display("FAIL starve_order[%0d]: got %c exp %c", i, order[i], exp_o); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req_i = 1; if_addr_i = 32'h1C0;
    tick(); mem_gnt_i = 1;
    tick(); mem_gnt_i = 0;
    rst_ni = 0; if_req_i = 0; #1;
    checks++; if (all_outs !== '0) begin errors++; $display("FAIL rmid_async: got %h exp 0", all_outs); end
    tick(); rst_ni = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
    tick(); mem_rvalid_i = 0;
    checks++; if (all_outs !== '0) begin errors++; $display("FAIL rmid_late_rvalid: got %h exp 0", all_outs); end
    if_req_i = 1; if_addr_i = 32'h400;
    tick();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h400}) begin
      errors++; $display("FAIL rmid_idle_restart: got %b %h exp 1 00000400", mem_req_o, mem_addr_o); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] mem_m [16];
    logic [31:0] f_addr = 0, d_addr = 0, d_wdata = 0, exp_if_rdata = 0, exp_d_rdata = 0;
    logic [36:0] exp_vec;
    logic [3:0]  d_be = 0;
    bit f_pend = 0, d_pend = 0, d_we = 0, own_data = 0, wait_rv = 0, rv_prev = 0, prev_req = 0;
    bit exp_data, exp_if_rv, exp_d_rv;
    int burst = 0, ntxn = 0, f_age = 0, d_age = 0;
    do_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      exp_if_rv = rv_prev && !own_data;
      exp_d_rv  = rv_prev && own_data;
      if (exp_if_rv) exp_if_rdata = mem_m[f_addr[5:2]];
      if (exp_d_rv && !d_we) exp_d_rdata = mem_m[d_addr[5:2]];
      checks++; if ({if_rvalid_o, d_rvalid_o} !== {exp_if_rv, exp_d_rv}) begin
        errors++; $display("FAIL rnd_rvalid cyc%0d: got %b%b exp %b%b", cyc, if_rvalid_o, d_rvalid_o, exp_if_rv, exp_d_rv); end
      checks++; if ({if_rdata_o, d_rdata_o} !== {exp_if_rdata, exp_d_rdata}) begin
        errors++; $display("FAIL rnd_rdata cyc%0d: got %h %h exp %h %h", cyc, if_rdata_o, d_rdata_o, exp_if_rdata, exp_d_rdata); end
      if (mem_req_o && !prev_req) begin
        exp_data = d_pend && !(GUARD && burst == MDB && f_pend);
        exp_vec  = exp_data ? {d_we, d_addr, d_be} : {1'b0, f_addr, 4'hF};
        checks++; if ({mem_we_o, mem_addr_o, mem_be_o} !== exp_vec) begin
          errors++; $display("FAIL rnd_grant cyc%0d: got %h exp %h", cyc, {mem_we_o, mem_addr_o, mem_be_o}, exp_vec); end
        if (exp_data && d_we) begin
          checks++; if (mem_wdata_o !== d_wdata) begin errors++; $display("FAIL rnd_wdata cyc%0d: got %h exp %h", cyc, mem_wdata_o, d_wdata); end
        end
        burst = (exp_data && f_pend) ? burst + 1 : 0;
        own_data = exp_data; ntxn++;
      end
      prev_req = mem_req_o;
      if (exp_if_rv) begin f_pend = 0; f_age = 0; end
      if (exp_d_rv)  begin d_pend = 0; d_age = 0; end
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = $urandom; rv_prev = 0;
      if (wait_rv) begin
        if ($urandom_range(0, 1) == 1) begin
          mem_rvalid_i = 1; rv_prev = 1; wait_rv = 0;
          if (!(own_data && d_we)) mem_rdata_i = own_data ? mem_m[d_addr[5:2]] : mem_m[f_addr[5:2]];
        end
      end else if (mem_req_o && $urandom_range(0, 1) == 1) begin
        mem_gnt_i = 1; wait_rv = 1;
        if (own_data && d_we)
          for (int b = 0; b < 4; b++) if (d_be[b]) mem_m[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
      end
      if (!f_pend && $urandom_range(0, 2) == 0) begin f_pend = 1; f_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00}; end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
      end
      if_req_i = f_pend; if_addr_i = f_addr;
      d_req_i = d_pend; d_we_i = d_we; d_addr_i = d_addr; d_wdata_i = d_wdata; d_be_i = d_be;
      #1;
      checks++; if ({if_stall_o, d_stall_o} !== {f_pend && !exp_if_rv, d_pend && !exp_d_rv}) begin
        errors++; $display("FAIL rnd_stall cyc%0d: got %b%b", cyc, if_stall_o, d_stall_o); end
      if (f_pend) f_age++;
      if (d_pend) d_age++;
      if (f_age > 300 || d_age > 300) begin
        errors++; $display("FAIL rnd_timeout cyc%0d: fetch age %0d data age %0d exp <= 300", cyc, f_age, d_age);
        break;
      end
    end
    checks++; if (ntxn < 100) begin errors++; $display("FAIL rnd_traffic: got %0d txns exp >= 100", ntxn); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_gnt_delay();
    test_flush();
    test_starve();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory between the instruction-fetch stage and the memory stage of the RISC-V pipeline. It accepts a fetch request and a data load/store request, grants one at a time over a req/gnt/rvalid memory handshake, and returns responses and per-stage stall signals to the pipeline. Data accesses take priority over fetch, with an optional starvation guard for fetch. It sits between the fetch and memory stages and the external memory port, alongside the hazard logic that consumes its stalls.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
- MAX_DATA_BURST, 4, consecutive contested data grants before fetch is forced (guard only)

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request, held until if_rvalid_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- flush_i  in  1  cancel the in-flight fetch (taken branch/jump)
- if_rvalid_o  out  1  one-cycle fetch response pulse
- if_rdata_o  out  DATA_WIDTH  fetched instruction, valid with if_rvalid_o
- if_stall_o  out  1  if_req_i & ~if_rvalid_o
- d_req_i, d_we_i  in  1  data request and write enable, held until d_rvalid_o
- d_addr_i  in  ADDR_WIDTH; d_wdata_i  in  DATA_WIDTH; d_be_i  in  DATA_WIDTH/8
- d_rvalid_o  out  1  one-cycle data response pulse (loads and stores)
- d_rdata_o  out  DATA_WIDTH  load data, valid with d_rvalid_o
- d_stall_o  out  1  d_req_i & ~d_rvalid_o
- mem_req_o, mem_we_o  out  1; mem_addr_o  out  ADDR_WIDTH; mem_wdata_o  out  DATA_WIDTH; mem_be_o  out  DATA_WIDTH/8
- mem_gnt_i  in  1  memory accepts the request this cycle
- mem_rvalid_i  in  1  memory response (also the write acknowledge)
- mem_rdata_i  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, REQ, RESP. One outstanding transaction at most.
- IDLE: if either request is high, arbitrate, latch the winner's owner/addr/we/wdata/be into registers, and go to REQ. Data wins unless the guard forces fetch. With no request, stay in IDLE.
- REQ: mem_req_o=1 and all mem_* fields come from registers and stay stable. Sampling mem_gnt_i=1 moves to RESP, and mem_req_o drops the next cycle. A fetch sets mem_we_o=0 and mem_be_o all ones.
- RESP: mem_rvalid_i=1 captures mem_rdata_i into the owner's rdata register, pulses the owner's rvalid_o the next cycle, and returns to IDLE.
- A request still high in the cycle its rvalid_o is high counts as a new request. Back-to-back transactions are legal.
- mem_rvalid_i is ignored in IDLE and REQ. The gnt→rvalid ordering is the memory's responsibility.
- flush_i while fetch owns the port (REQ or RESP, including the capture cycle) sets a discard flag. The transaction still completes on the memory side, if_rvalid_o is suppressed, and if_rdata_o is unchanged. The flag clears on return to IDLE. flush_i in IDLE, while data owns the port, or in the if_rvalid_o cycle has no effect.
- rdata outputs hold their last value between pulses.
- Reset: state=IDLE and every output is 0, including rdata outputs, registers and counter. A reset mid-transaction abandons it, and any later mem_rvalid_i is ignored.

## Timing
- Request seen in IDLE at cycle 0 gives mem_req_o at cycle 1.
- With mem_gnt_i at cycle 1, the FSM is in RESP at cycle 2.
- With mem_rvalid_i at cycle 2, rvalid_o fires at cycle 3. Minimum latency is 3 cycles, plus gnt and rvalid wait states.
- Stalls are combinational from req_i and registered rvalid_o. No other combinational input→output paths exist.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A counter of width clog2(MAX_DATA_BURST+1) increments on each data grant made while if_req_i was also high.
  - It resets to 0 on any fetch grant or on an uncontested data grant.
  - When it equals MAX_DATA_BURST and both requests are high, fetch wins.
- Undefined: no counter exists, and data always wins.

## Test plan
- Single fetch, addr 0x100, gnt at cycle 1, rvalid with 0x00000013 at cycle 2 → if_rvalid_o=1 with if_rdata_o=0x00000013 at cycle 3, mem_we_o=0, if_stall_o=1 for cycles 0–2.
- Both requests at cycle 0, store addr 0x200 data 0xDEADBEEF be 0xF → data granted first (mem_we_o=1), fetch issued after d_rvalid_o. d_rdata_o unchanged.
- gnt delayed 3 cycles → mem_* fields stable for all REQ cycles, mem_req_o low the cycle after gnt.
- flush_i during fetch RESP → no if_rvalid_o pulse. A new fetch to 0x300 then completes normally.
- Guard on, MAX_DATA_BURST=4, both requests held continuously → grant order D,D,D,D,F. Guard off → data only.
- rst_ni low while in RESP, then mem_rvalid_i after release → all outputs 0, no rvalid_o pulse, FSM in IDLE.
